inst_rom_srv: RTL and testbench

Instruction-memory responder on the core's fetch port: it answers the core's `pc2rom` address with `rom_ins` in the same cycle, and holds the program image the core executes. The image is written at runtime from a byte-wide loader stream (little-endian, four bytes per word). The block sits beside the `riscv` top, driving `rom_ins` and stalling the core through `core_hold` until a complete image is present.

---
 rtl/riscv_defs.sv | 16 +
 rtl/inst_rom_srv_word_packer.sv | 40 ++++
 rtl/inst_rom_srv.sv | 120 ++++++++++++
 tb/tb_inst_rom_srv.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/riscv_defs.sv
// Shared definitions for the instruction-ROM responder: fetch defaults,
// responder state encoding and fetch address alignment.
package riscv_defs;

  localparam logic [31:0] NOP_INS = 32'h0000_0013;

  // Byte address to word index.
  localparam int WORD_SHIFT = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } rom_state_t;

endpackage

// File: rtl/inst_rom_srv_word_packer.sv
// Little-endian byte-to-word assembler for the image loader stream.
// Raises word_valid combinationally on the byte that completes a word.
module word_packer (
  input  logic        clki,
  input  logic        rsti,
  input  logic        flush,
  input  logic        byte_valid,
  input  logic [7:0]  byte_in,
  output logic        word_valid,
  output logic [31:0] word,
  output logic        partial
);

  logic [1:0]  cnt;
  logic [23:0] acc;

  always_ff @(posedge clki or negedge rsti) begin
    if (!rsti) begin
      cnt <= 2'd0;
      acc <= 24'd0;
    end else if (flush) begin
      cnt <= 2'd0;
    end else if (byte_valid) begin
      case (cnt)
        2'd0:    acc[7:0]   <= byte_in;
        2'd1:    acc[15:8]  <= byte_in;
        2'd2:    acc[23:16] <= byte_in;
        default: acc        <= acc;
      endcase
      cnt <= cnt + 2'd1;
    end
  end

  assign word_valid = byte_valid && (cnt == 2'd3);
  assign word       = {byte_in, acc};

  // Byte counter as it stands after this cycle's byte, if any, is taken.
  assign partial    = byte_valid ? (cnt != 2'd3) : (cnt != 2'd0);

endmodule

// File: rtl/inst_rom_srv.sv
// Instruction-memory responder: serves combinational fetches from a
// runtime-loaded image and holds the core until a full image exists.
module inst_rom_srv #(
  parameter int          DEPTH_WORDS = 1024,
  parameter int          ADDR_W      = 10,
  parameter logic [31:0] NOP_INS     = riscv_defs::NOP_INS
) (
  input  logic              clki,
  input  logic              rsti,
  input  logic [31:0]       pc2rom,
  output logic [31:0]       rom_ins,
  output logic              core_hold,
  input  logic              load_start,
  input  logic              load_valid,
  input  logic [7:0]        load_byte,
  output logic              load_ready,
  input  logic              load_done,
  output logic [ADDR_W:0]   load_count,
  output logic              load_err
);
  import riscv_defs::*;

  // state | meaning
  // IDLE  | out of reset, no image; core held
  // LOAD  | image being written from the byte stream; core held
  // RUN   | image complete; fetches served from the array

  localparam logic [ADDR_W:0] DEPTH_CNT = (ADDR_W+1)'(DEPTH_WORDS);

  rom_state_t state, next_state;

  logic [31:0]       mem [DEPTH_WORDS];
  logic [ADDR_W-1:0] wptr;

  logic        accept;
  logic        flush;
  logic        word_valid;
  logic [31:0] word;
  logic        partial;
  logic        word_done;
  logic        write_en;
  logic        overflow;

  logic [31-WORD_SHIFT:0] pc_word;
  logic                   aligned;
  logic                   in_range;

  always_ff @(posedge clki or negedge rsti) begin
    if (!rsti) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    if (load_start)
      next_state = LOAD;
    else if (state == LOAD && load_done)
      next_state = RUN;
  end

  always_comb begin
    load_ready = (state == LOAD);
    core_hold  = (state != RUN);
  end

  assign accept = load_valid && load_ready;
  assign flush  = load_start || (state == LOAD && load_done);

  word_packer u_packer (
    .clki       (clki),
    .rsti       (rsti),
    .flush      (flush),
    .byte_valid (accept),
    .byte_in    (load_byte),
    .word_valid (word_valid),
    .word       (word),
    .partial    (partial)
  );

  // A restart in the same cycle discards whatever the old image was completing.
  assign word_done = word_valid && !load_start;
  assign write_en  = word_done && (load_count != DEPTH_CNT);
  assign overflow  = word_done && (load_count == DEPTH_CNT);

  always_ff @(posedge clki or negedge rsti) begin
    if (!rsti) begin
      wptr       <= '0;
      load_count <= '0;
      load_err   <= 1'b0;
    end else if (load_start) begin
      wptr       <= '0;
      load_count <= '0;
      load_err   <= 1'b0;
    end else if (state == LOAD) begin
      if (write_en) begin
        wptr       <= wptr + ADDR_W'(1);
        load_count <= load_count + (ADDR_W+1)'(1);
      end
      if (overflow || (load_done && partial))
        load_err <= 1'b1;
    end
  end

  // Array has no reset; stale words stay unreachable behind load_count.
  always_ff @(posedge clki) begin
    if (write_en)
      mem[wptr] <= word;
  end

  assign pc_word  = pc2rom[31:WORD_SHIFT];
  assign aligned  = (pc2rom[WORD_SHIFT-1:0] == '0);
  assign in_range = (pc_word < (32-WORD_SHIFT)'(load_count));

  always_comb begin
    rom_ins = NOP_INS;
    if (state == RUN && aligned && in_range)
      rom_ins = mem[pc_word[ADDR_W-1:0]];
  end

endmodule

// File: tb/tb_inst_rom_srv.sv
// Directed bench: a full-depth responder and a 4-word responder share stimulus.
module tb_inst_rom_srv;

  logic        clk;
  logic        rst_n;
  logic [31:0] pc;
  logic        start;
  logic        valid;
  logic [7:0]  byte_d;
  logic        done;

  logic [31:0] ins_a, ins_b;
  logic        hold_a, hold_b;
  logic        ready_a, ready_b;
  logic [10:0] count_a;
  logic [2:0]  count_b;
  logic        err_a, err_b;

  int checks = 0;
  int errors = 0;

  inst_rom_srv #(.DEPTH_WORDS(1024), .ADDR_W(10)) dut_a (
    .clki(clk), .rsti(rst_n), .pc2rom(pc), .rom_ins(ins_a), .core_hold(hold_a),
    .load_start(start), .load_valid(valid), .load_byte(byte_d), .load_ready(ready_a),
    .load_done(done), .load_count(count_a), .load_err(err_a)
  );

  inst_rom_srv #(.DEPTH_WORDS(4), .ADDR_W(2)) dut_b (
    .clki(clk), .rsti(rst_n), .pc2rom(pc), .rom_ins(ins_b), .core_hold(hold_b),
    .load_start(start), .load_valid(valid), .load_byte(byte_d), .load_ready(ready_b),
    .load_done(done), .load_count(count_b), .load_err(err_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic send_byte(input logic [7:0] b);
    valid  = 1'b1;
    byte_d = b;
    cyc();
    valid  = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  task automatic pulse_done();
    done = 1'b1;
    cyc();
    done = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; pc = 32'h0; start = 0; valid = 0; byte_d = 8'h00; done = 0;
    #3;
    checks++; if (hold_a !== 1'b1) begin errors++; $display("FAIL reset_hold: got %b expected 1", hold_a); end
    checks++; if (ready_a !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b expected 0", ready_a); end
    checks++; if (count_a !== 11'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", count_a); end
    checks++; if (err_a !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", err_a); end
    checks++; if (ins_a !== 32'h0000_0013) begin errors++; $display("FAIL reset_fetch0: got %h expected 00000013", ins_a); end
    #20;
    rst_n = 1'b1;
    pc = 32'h4; cyc();
    checks++; if (ins_a !== 32'h0000_0013) begin errors++; $display("FAIL idle_fetch4: got %h expected 00000013", ins_a); end
    pc = 32'h100; #1;
    checks++; if (ins_a !== 32'h0000_0013) begin errors++; $display("FAIL idle_fetch100: got %h expected 00000013", ins_a); end
    checks++; if (hold_a !== 1'b1) begin errors++; $display("FAIL idle_hold: got %b expected 1", hold_a); end
    // done in IDLE is ignored
    pulse_done();
    checks++; if (hold_a !== 1'b1) begin errors++; $display("FAIL idle_done_ignored: got %b expected 1", hold_a); end
  endtask

  task automatic test_basic_load();
    logic [7:0] img [8] = '{8'h13, 8'h05, 8'h10, 8'h00, 8'h93, 8'h05, 8'h20, 8'h00};
    // byte offered together with start must be dropped
    valid = 1'b1; byte_d = 8'hAA;
    pulse_start();
    valid = 1'b0;
    checks++; if (ready_a !== 1'b1) begin errors++; $display("FAIL start_ready: got %b expected 1", ready_a); end
    checks++; if (count_a !== 11'd0) begin errors++; $display("FAIL start_byte_dropped: got %0d expected 0", count_a); end
    for (int i = 0; i < 8; i++) send_byte(img[i]);
    checks++; if (count_a !== 11'd2) begin errors++; $display("FAIL load_count_pre: got %0d expected 2", count_a); end
    pc = 32'h0; #1;
    checks++; if (ins_a !== 32'h0000_0013) begin errors++; $display("FAIL load_state_fetch: got %h expected 00000013", ins_a); end
    checks++; if (hold_a !== 1'b1) begin errors++; $display("FAIL load_hold: got %b expected 1", hold_a); end
    pulse_done();
    checks++; if (hold_a !== 1'b0) begin errors++; $display("FAIL run_hold: got %b expected 0", hold_a); end
    checks++; if (ready_a !== 1'b0) begin errors++; $display("FAIL run_ready: got %b expected 0", ready_a); end
    checks++; if (count_a !== 11'd2) begin errors++; $display("FAIL run_count: got %0d expected 2", count_a); end
    checks++; if (err_a !== 1'b0) begin errors++; $display("FAIL run_err: got %b expected 0", err_a); end
    pc = 32'h0; #1;
    checks++; if (ins_a !== 32'h0010_0513) begin errors++; $display("FAIL fetch0: got %h expected 00100513", ins_a); end
    pc = 32'h4; #1;
    checks++; if (ins_a !== 32'h0020_0593) begin errors++; $display("FAIL fetch4: got %h expected 00200593", ins_a); end
    pc = 32'h8; #1;
    checks++; if (ins_a !== 32'h0000_0013) begin errors++; $display("FAIL fetch8_nop: got %h expected 00000013", ins_a); end
    pc = 32'h2; #1;
    checks++; if (ins_a !== 32'h0000_0013) begin errors++; $display("FAIL fetch_misaligned: got %h expected 00000013", ins_a); end
    pc = 32'h4000_0000; #1;
    checks++; if (ins_a !== 32'h0000_0013) begin errors++; $display("FAIL fetch_high: got %h expected 00000013", ins_a); end
    pulse_done();
    checks++; if (hold_a !== 1'b0) begin errors++; $display("FAIL run_done_ignored: got %b expected 0", hold_a); end
  endtask

  task automatic test_partial();
    pulse_start();
    for (int i = 1; i <= 6; i++) send_byte(8'(i));
    pulse_done();
    checks++; if (count_a !== 11'd1) begin errors++; $display("FAIL partial_count: got %0d expected 1", count_a); end
    checks++; if (err_a !== 1'b1) begin errors++; $display("FAIL partial_err: got %b expected 1", err_a); end
    checks++; if (hold_a !== 1'b0) begin errors++; $display("FAIL partial_run: got %b expected 0", hold_a); end
    pc = 32'h0; #1;
    checks++; if (ins_a !== 32'h0403_0201) begin errors++; $display("FAIL partial_fetch0: got %h expected 04030201", ins_a); end
    pc = 32'h4; #1;
    checks++; if (ins_a !== 32'h0000_0013) begin errors++; $display("FAIL partial_fetch4: got %h expected 00000013", ins_a); end
  endtask

  task automatic test_start_done();
    start = 1'b1; done = 1'b1;
    cyc();
    start = 1'b0; done = 1'b0;
    checks++; if (ready_a !== 1'b1) begin errors++; $display("FAIL startdone_ready: got %b expected 1", ready_a); end
    checks++; if (hold_a !== 1'b1) begin errors++; $display("FAIL startdone_hold: got %b expected 1", hold_a); end
    checks++; if (err_a !== 1'b0) begin errors++; $display("FAIL startdone_err_clr: got %b expected 0", err_a); end
    checks++; if (count_a !== 11'd0) begin errors++; $display("FAIL startdone_count: got %0d expected 0", count_a); end
  endtask

  task automatic test_byte_with_done();
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
    valid = 1'b1; byte_d = 8'h44; done = 1'b1;
    cyc();
    valid = 1'b0; done = 1'b0;
    checks++; if (count_a !== 11'd1) begin errors++; $display("FAIL bytedone_count: got %0d expected 1", count_a); end
    checks++; if (err_a !== 1'b0) begin errors++; $display("FAIL bytedone_err: got %b expected 0", err_a); end
    checks++; if (hold_a !== 1'b0) begin errors++; $display("FAIL bytedone_run: got %b expected 0", hold_a); end
    pc = 32'h0; #1;
    checks++; if (ins_a !== 32'h4433_2211) begin errors++; $display("FAIL bytedone_fetch0: got %h expected 44332211", ins_a); end
  endtask

  task automatic test_reset_midload();
    pulse_start();
    for (int i = 0; i < 12; i++) send_byte(8'hC0 + 8'(i));
    checks++; if (count_a !== 11'd3) begin errors++; $display("FAIL midload_count3: got %0d expected 3", count_a); end
    rst_n = 1'b0; #1;
    checks++; if (count_a !== 11'd0) begin errors++; $display("FAIL midload_rst_count: got %0d expected 0", count_a); end
    checks++; if (ready_a !== 1'b0) begin errors++; $display("FAIL midload_rst_ready: got %b expected 0", ready_a); end
    checks++; if (hold_a !== 1'b1) begin errors++; $display("FAIL midload_rst_hold: got %b expected 1", hold_a); end
    pc = 32'h0; #1;
    checks++; if (ins_a !== 32'h0000_0013) begin errors++; $display("FAIL midload_rst_fetch: got %h expected 00000013", ins_a); end
    #10;
    rst_n = 1'b1;
    cyc();
    checks++; if (hold_a !== 1'b1) begin errors++; $display("FAIL midload_idle_after: got %b expected 1", hold_a); end
  endtask

  task automatic test_overflow();
    logic [31:0] exp_w [4] = '{32'h0403_0201, 32'h0807_0605, 32'h0C0B_0A09, 32'h100F_0E0D};
    pulse_start();
    for (int i = 1; i <= 16; i++) send_byte(8'(i));
    checks++; if (count_b !== 3'd4) begin errors++; $display("FAIL ovf_full_count: got %0d expected 4", count_b); end
    checks++; if (err_b !== 1'b0) begin errors++; $display("FAIL ovf_full_err: got %b expected 0", err_b); end
    for (int i = 17; i <= 20; i++) send_byte(8'(i));
    checks++; if (count_b !== 3'd4) begin errors++; $display("FAIL ovf_count: got %0d expected 4", count_b); end
    checks++; if (err_b !== 1'b1) begin errors++; $display("FAIL ovf_err: got %b expected 1", err_b); end
    checks++; if (count_a !== 11'd5) begin errors++; $display("FAIL deep_count5: got %0d expected 5", count_a); end
    checks++; if (err_a !== 1'b0) begin errors++; $display("FAIL deep_err: got %b expected 0", err_a); end
    pulse_done();
    checks++; if (err_b !== 1'b1) begin errors++; $display("FAIL ovf_err_sticky: got %b expected 1", err_b); end
    for (int k = 0; k < 4; k++) begin
      pc = 32'(k * 4); #1;
      checks++;
      if (ins_b !== exp_w[k]) begin
        errors++; $display("FAIL ovf_fetch%0d: got %h expected %h", k, ins_b, exp_w[k]);
      end
    end
    pc = 32'h10; #1;
    checks++; if (ins_b !== 32'h0000_0013) begin errors++; $display("FAIL ovf_fetch16: got %h expected 00000013", ins_b); end
    checks++; if (ins_a !== 32'h1413_1211) begin errors++; $display("FAIL deep_fetch16: got %h expected 14131211", ins_a); end
  endtask

  initial begin
    test_reset();
    test_basic_load();
    test_partial();
    test_start_done();
    test_byte_with_done();
    test_reset_midload();
    test_overflow();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
